// File: rtl/leaf_net_iface.sv
// leaf_net_iface: network interface between one processing element and one
// child port of a leaf router in the binary-tree NoC.
//   TX path: PE word -> 20-bit packet {type, sender, receiver, data} -> FIFO -> router.
//   RX path: router packet -> address check -> {type, sender, data} -> FIFO -> PE.
// Packets whose receiver field is not NODE_ADDR are still consumed, but they
// are dropped and the sticky err_misroute flag is raised.
// Optional feature macro: LEAF_NET_IFACE_STATS_EN adds saturating 16-bit
// tx/rx/drop event counters as extra outputs.

// Small synchronous FIFO. The pointers carry one extra wrap bit so that full
// and empty can be told apart when the indices are equal. Storage is cleared
// on reset so the head word reads as zero straight out of reset.
module leaf_net_iface_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // Callers already gate with full/empty; the extra gating keeps the FIFO safe on its own.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance and storage write; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

module leaf_net_iface #(
  parameter logic [4:0] NODE_ADDR = 5'd1,
  parameter int         TX_DEPTH  = 4,
  parameter int         RX_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // PE transmit side
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  input  logic [1:0]  i_tx_type,
  input  logic [4:0]  i_tx_dest,
  input  logic [7:0]  i_tx_data,
  // router child input
  output logic        o_pkt_out_valid,
  input  logic        i_pkt_out_ready,
  output logic [19:0] o_pkt_out,
  // router child output
  input  logic        i_pkt_in_valid,
  output logic        o_pkt_in_ready,
  input  logic [19:0] i_pkt_in,
  // PE receive side
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic [1:0]  o_rx_type,
  output logic [4:0]  o_rx_src,
  output logic [7:0]  o_rx_data,
  // error reporting
  output logic        o_err_misroute,
  input  logic        i_err_clr
`ifdef LEAF_NET_IFACE_STATS_EN
  ,
  output logic [15:0] o_tx_count,
  output logic [15:0] o_rx_count,
  output logic [15:0] o_drop_count
`endif
);

  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [19:0] w_tx_pkt;

  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_in_fire;
  logic        w_addr_ok;
  logic        w_misroute;
  logic [14:0] w_rx_entry;
  logic [14:0] w_rx_head;

  logic        r_err_misroute;

  // ---------------- transmit path ----------------
  // tx_ready only looks at occupancy: no pass-through when the FIFO is full.
  assign o_tx_ready      = !w_tx_full;
  assign o_pkt_out_valid = !w_tx_empty;
  assign w_tx_push       = i_tx_valid && !w_tx_full;
  assign w_tx_pop        = !w_tx_empty && i_pkt_out_ready;
  // Self-addressed packets are sent as-is; the router turns them around.
  assign w_tx_pkt        = {i_tx_type, NODE_ADDR, i_tx_dest, i_tx_data};

  leaf_net_iface_fifo #(
    .W     (20),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_data  (w_tx_pkt),
    .i_pop   (w_tx_pop),
    .o_data  (o_pkt_out),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // ---------------- receive path ----------------
  // A misaddressed packet is still accepted so the router never stalls on it.
  assign o_pkt_in_ready = !w_rx_full;
  assign w_in_fire      = i_pkt_in_valid && !w_rx_full;
  assign w_addr_ok      = (i_pkt_in[12:8] == NODE_ADDR);
  assign w_rx_push      = w_in_fire && w_addr_ok;
  assign w_misroute     = w_in_fire && !w_addr_ok;
  assign w_rx_entry     = {i_pkt_in[19:18], i_pkt_in[17:13], i_pkt_in[7:0]};
  assign w_rx_pop       = !w_rx_empty && i_rx_ready;

  leaf_net_iface_fifo #(
    .W     (15),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_data  (w_rx_entry),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign o_rx_valid = !w_rx_empty;
  assign o_rx_type  = w_rx_head[14:13];
  assign o_rx_src   = w_rx_head[12:8];
  assign o_rx_data  = w_rx_head[7:0];

  // Sticky misroute flag; a new misroute beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_misroute <= 1'b0;
    end else if (w_misroute) begin
      r_err_misroute <= 1'b1;
    end else if (i_err_clr) begin
      r_err_misroute <= 1'b0;
    end
  end

  assign o_err_misroute = r_err_misroute;

`ifdef LEAF_NET_IFACE_STATS_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;
  logic [15:0] r_drop_count;

  // Saturating event counters: sent packets, accepted packets, dropped packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_count   <= 16'd0;
      r_rx_count   <= 16'd0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_tx_pop && (r_tx_count != CNT_MAX)) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
      if (w_rx_push && (r_rx_count != CNT_MAX)) begin
        r_rx_count <= r_rx_count + 16'd1;
      end
      if (w_misroute && (r_drop_count != CNT_MAX)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign o_tx_count   = r_tx_count;
  assign o_rx_count   = r_rx_count;
  assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_leaf_net_iface.sv
// Self-checking bench for leaf_net_iface: per-cycle vector table plus
// hand-written sequences; packet contents are checked by queue scoreboards.
module tb_leaf_net_iface;
  localparam logic [4:0] NODE = 5'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [1:0]  tx_type = 2'd0;
  logic [4:0]  tx_dest = 5'd0;
  logic [7:0]  tx_data = 8'd0;
  logic        pkt_out_ready = 1'b0;
  logic        pkt_in_valid = 1'b0;
  logic [19:0] pkt_in = 20'd0;
  logic        rx_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        o_tx_ready;
  logic        o_pkt_out_valid;
  logic [19:0] o_pkt_out;
  logic        o_pkt_in_ready;
  logic        o_rx_valid;
  logic [1:0]  o_rx_type;
  logic [4:0]  o_rx_src;
  logic [7:0]  o_rx_data;
  logic        o_err_misroute;
`ifdef LEAF_NET_IFACE_STATS_EN
  logic [15:0] o_tx_count;
  logic [15:0] o_rx_count;
  logic [15:0] o_drop_count;
`endif

  int total = 0;
  int bad = 0;
  int m_tx = 0;
  int m_rx = 0;
  int m_drop = 0;
  logic [19:0] tx_q[$];
  logic [14:0] rx_q[$];

  leaf_net_iface #(.NODE_ADDR(NODE), .TX_DEPTH(4), .RX_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_tx_valid      (tx_valid),
    .o_tx_ready      (o_tx_ready),
    .i_tx_type       (tx_type),
    .i_tx_dest       (tx_dest),
    .i_tx_data       (tx_data),
    .o_pkt_out_valid (o_pkt_out_valid),
    .i_pkt_out_ready (pkt_out_ready),
    .o_pkt_out       (o_pkt_out),
    .i_pkt_in_valid  (pkt_in_valid),
    .o_pkt_in_ready  (o_pkt_in_ready),
    .i_pkt_in        (pkt_in),
    .o_rx_valid      (o_rx_valid),
    .i_rx_ready      (rx_ready),
    .o_rx_type       (o_rx_type),
    .o_rx_src        (o_rx_src),
    .o_rx_data       (o_rx_data),
    .o_err_misroute  (o_err_misroute),
    .i_err_clr       (err_clr)
`ifdef LEAF_NET_IFACE_STATS_EN
    ,
    .o_tx_count      (o_tx_count),
    .o_rx_count      (o_rx_count),
    .o_drop_count    (o_drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] pk(input logic [1:0] t, input logic [4:0] s,
                                     input logic [4:0] r, input logic [7:0] d);
    return {t, s, r, d};
  endfunction

  // Scoreboard: expectations pushed at input handshakes, compared at output handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_pkt_out_valid && pkt_out_ready) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected_pkt", 32'(o_pkt_out), 32'hFFFFFFFF);
        end else begin
          check("pkt_out_data", 32'(o_pkt_out), 32'(tx_q.pop_front()));
        end
        m_tx++;
      end
      if (tx_valid && o_tx_ready) begin
        tx_q.push_back({tx_type, NODE, tx_dest, tx_data});
      end
      if (o_rx_valid && rx_ready) begin
        if (rx_q.size() == 0) begin
          check("rx_unexpected_word", 32'({o_rx_type, o_rx_src, o_rx_data}), 32'hFFFFFFFF);
        end else begin
          check("rx_word", 32'({o_rx_type, o_rx_src, o_rx_data}), 32'(rx_q.pop_front()));
        end
      end
      if (pkt_in_valid && o_pkt_in_ready) begin
        if (pkt_in[12:8] == NODE) begin
          rx_q.push_back({pkt_in[19:18], pkt_in[17:13], pkt_in[7:0]});
          m_rx++;
        end else begin
          m_drop++;
        end
      end
    end
  end

  typedef struct {
    logic        tv;
    logic [7:0]  td;
    logic        tor;
    logic        piv;
    logic [19:0] pin;
    logic        rr;
    logic        clr;
    logic        e_txr;
    logic        e_pov;
    logic        e_pir;
    logic        e_rxv;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic tv, input logic [7:0] td, input logic tor,
                              input logic piv, input logic [19:0] pin, input logic rr,
                              input logic clr, input logic e_txr, input logic e_pov,
                              input logic e_pir, input logic e_rxv, input logic e_err);
    vec_t v;
    v.tv = tv; v.td = td; v.tor = tor; v.piv = piv; v.pin = pin; v.rr = rr; v.clr = clr;
    v.e_txr = e_txr; v.e_pov = e_pov; v.e_pir = e_pir; v.e_rxv = e_rxv; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic tv, input logic [7:0] td, input logic tor,
                       input logic piv, input logic [19:0] pin, input logic rr, input logic clr);
    tx_valid = tv; tx_data = td; tx_type = td[1:0]; tx_dest = td[6:2];
    pkt_out_ready = tor; pkt_in_valid = piv; pkt_in = pin; rx_ready = rr; err_clr = clr;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_ready"}, 32'(o_tx_ready), 32'd1);
    check({tag, "_pkt_out_valid"}, 32'(o_pkt_out_valid), 32'd0);
    check({tag, "_pkt_out"}, 32'(o_pkt_out), 32'd0);
    check({tag, "_pkt_in_ready"}, 32'(o_pkt_in_ready), 32'd1);
    check({tag, "_rx_valid"}, 32'(o_rx_valid), 32'd0);
    check({tag, "_rx_fields"}, 32'({o_rx_type, o_rx_src, o_rx_data}), 32'd0);
    check({tag, "_err"}, 32'(o_err_misroute), 32'd0);
`ifdef LEAF_NET_IFACE_STATS_EN
    check({tag, "_stat_tx"}, 32'(o_tx_count), 32'd0);
    check({tag, "_stat_rx"}, 32'(o_rx_count), 32'd0);
    check({tag, "_stat_drop"}, 32'(o_drop_count), 32'd0);
`endif
  endtask

  vec_t vecs[13];
  int   tx_before;
  int   rx_before;

  initial begin
    // Table: one row per cycle; expected outputs are those seen before the edge.
    vecs[0]  = mk(1'b1, 8'h11, 1'b0, 1'b1, pk(2'd1, 5'd7, 5'd1, 8'h3C), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 8'h22, 1'b0, 1'b1, pk(2'd2, 5'd2, 5'd1, 8'h55), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 8'h33, 1'b0, 1'b1, pk(2'd3, 5'd3, 5'd1, 8'h66), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 8'h05, 1'b0, 1'b1, pk(2'd3, 5'd3, 5'd1, 8'h66), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 8'h55, 1'b0, 1'b1, pk(2'd3, 5'd3, 5'd1, 8'h66), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(1'b1, 8'h55, 1'b1, 1'b1, pk(2'd3, 5'd3, 5'd1, 8'h66), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, pk(2'd3, 5'd3, 5'd1, 8'h66), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, pk(2'd0, 5'd7, 5'd5, 8'h99), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 8'h00, 1'b1, 1'b1, pk(2'd1, 5'd4, 5'd6, 8'h12), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 20'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Power-on reset.
    #12;
    check_reset_values("por");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single TX: exact packet image, held while router is not ready.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
    tx_type = 2'b10; tx_dest = 5'd9;
    @(negedge clk);
    check("single_pov_before", 32'(o_pkt_out_valid), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("single_pov_hold%0d", k), 32'(o_pkt_out_valid), 32'd1);
      check($sformatf("single_pkt_hold%0d", k), 32'(o_pkt_out), 32'h000829A5);
      @(posedge clk); #1;
    end
    pkt_out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("single_pov_after", 32'(o_pkt_out_valid), 32'd0);
    @(posedge clk); #1;

    // Table-driven: TX fill/drain, RX back-pressure, misroute and err_clr priority.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].tv, vecs[i].td, vecs[i].tor, vecs[i].piv, vecs[i].pin, vecs[i].rr, vecs[i].clr);
      @(negedge clk);
      check($sformatf("v%0d_tx_ready", i), 32'(o_tx_ready), 32'(vecs[i].e_txr));
      check($sformatf("v%0d_pkt_out_valid", i), 32'(o_pkt_out_valid), 32'(vecs[i].e_pov));
      check($sformatf("v%0d_pkt_in_ready", i), 32'(o_pkt_in_ready), 32'(vecs[i].e_pir));
      check($sformatf("v%0d_rx_valid", i), 32'(o_rx_valid), 32'(vecs[i].e_rxv));
      check($sformatf("v%0d_err", i), 32'(o_err_misroute), 32'(vecs[i].e_err));
      @(posedge clk); #1;
    end

    // Streaming both directions for 20 cycles with ready held high.
    tx_before = m_tx;
    rx_before = m_rx;
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        drive(1'b1, 8'($urandom), 1'b1, 1'b1,
              pk(2'(k), 5'(k), NODE, 8'($urandom)), 1'b1, 1'b0);
      end else begin
        drive(1'b0, 8'h00, 1'b1, 1'b0, 20'd0, 1'b1, 1'b0);
      end
      @(negedge clk);
      if (k < 20) begin
        check($sformatf("stream%0d_tx_ready", k), 32'(o_tx_ready), 32'd1);
        check($sformatf("stream%0d_pkt_in_ready", k), 32'(o_pkt_in_ready), 32'd1);
      end
      check($sformatf("stream%0d_pov", k), 32'(o_pkt_out_valid), 32'((k >= 1) && (k <= 20)));
      check($sformatf("stream%0d_rxv", k), 32'(o_rx_valid), 32'((k >= 1) && (k <= 20)));
      @(posedge clk); #1;
    end
    check("stream_tx_count", 32'(m_tx - tx_before), 32'd20);
    check("stream_rx_count", 32'(m_rx - rx_before), 32'd20);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    // Partially fill both FIFOs and raise the error, then reset asynchronously.
    drive(1'b1, 8'h77, 1'b0, 1'b1, pk(2'd2, 5'd9, NODE, 8'hAB), 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 8'h88, 1'b0, 1'b1, pk(2'd0, 5'd4, 5'd5, 8'h01), 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
    check("pre_rst_pov", 32'(o_pkt_out_valid), 32'd1);
    check("pre_rst_rxv", 32'(o_rx_valid), 32'd1);
    check("pre_rst_err", 32'(o_err_misroute), 32'd1);
`ifdef LEAF_NET_IFACE_STATS_EN
    check("pre_rst_stat_tx", 32'(o_tx_count), 32'(m_tx));
    check("pre_rst_stat_rx", 32'(o_rx_count), 32'(m_rx));
    check("pre_rst_stat_drop", 32'(o_drop_count), 32'(m_drop));
`endif
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    tx_q.delete();
    rx_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
